pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter register and drives the select line of the next-PC source mux (sequential PC+1 vs. branch/jump target).
- Sequences fetch through reset, normal run, pipeline stall, and post-redirect flush.
- Sits between the branch/jump resolution logic (EX/ID) and instruction memory addressing in the mini CPU.
- PC is word-addressed: the sequential increment is +1.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 1, bubble cycles (fetch_valid low) after an accepted redirect; legal range 1..7.
- TRAP_VECTOR, 32'h00000010, trap handler address; used only with PC_TRAP_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC (IF/ID hazard).
- br_taken  input  1  conditional branch resolved taken (EX stage).
- br_target  input  WIDTH  branch target address.
- jump  input  1  unconditional jump decoded (ID stage).
- jump_target  input  WIDTH  jump target address.
- pc  output  WIDTH  registered current fetch address.
- npc  output  WIDTH  combinational next PC.
- pc_src  output  1  combinational mux select: 0 = PC+1, 1 = branch/jump target.
- fetch_valid  output  1  registered; instruction at pc is to be issued.
- flush  output  1  registered; younger pipeline stages are squashed.
- redirect_cnt  output  16  registered count of accepted redirects; wraps.

Behaviour:
- Reset: rst high at a clock edge sets pc=RESET_PC, state=BOOT, fetch_valid=0, flush=0, redirect_cnt=0, and clears the flush counter. Reset overrides every other input, including in the middle of a flush.
- States:
  - BOOT: one cycle with fetch_valid=0. Always goes to RUN on the next edge. pc holds.
  - RUN: fetch_valid=1.
  - STALL: fetch_valid=0, pc holds.
  - FLUSH: fetch_valid=0, flush=1.
- Redirect priority (evaluated every cycle in RUN, STALL and FLUSH):
  - br_taken beats jump, because the branch is the older instruction.
  - Any redirect beats stall.
  - In BOOT, redirect inputs are ignored.
- Accepted redirect:
  - pc_src=1 in the same cycle; npc = br_target if br_taken, else jump_target.
  - Next edge: pc=npc, state=FLUSH, flush counter loaded with FLUSH_CYCLES, redirect_cnt+1.
- FLUSH:
  - Counter decrements each cycle.
  - When it reaches 1 and no new redirect arrives, the next state is STALL if stall=1, else RUN.
  - pc holds during FLUSH unless a new redirect arrives, which reloads the counter.
- RUN/STALL with no redirect: stall=1 means pc holds and the state is STALL; stall=0 means pc=pc+1 and the state is RUN.
- Sequential increment wraps modulo 2^WIDTH (all-ones + 1 = 0).
- pc_src=0 whenever no redirect is accepted; npc = pc+1 if advancing, else pc.
- redirect_cnt wraps from 16'hFFFF to 0.
- Latency:
  - A redirect asserted in cycle N appears on pc at N+1.
  - fetch_valid returns to 1 at N+1+FLUSH_CYCLES, provided stall=0.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined:
  - Adds port trap (input, 1) and port epc (output, WIDTH, registered, reset 0).
  - trap has the highest priority after rst, including in BOOT.
  - On trap: pc=TRAP_VECTOR, epc=pc (address of the faulting fetch), enter FLUSH, redirect_cnt+1, pc_src=1, npc=TRAP_VECTOR.
- Undefined: no trap/epc ports; behaviour exactly as above.

Test Plan:
- Reset with RESET_PC=0, then rst released with stall=0 → cycle 1: pc=0, fetch_valid=0; cycle 2: fetch_valid=1; next edges: pc=1, 2, 3.
- At pc=5 pulse br_taken=1 with br_target=32'h40 → pc_src=1 and npc=32'h40 that cycle; next edge pc=32'h40, flush=1, fetch_valid=0 for 1 cycle, then pc advances to 32'h41; redirect_cnt=1.
- Same cycle: br_taken=1 (br_target=32'h80), jump=1 (jump_target=32'h20), stall=1 → pc=32'h80, redirect_cnt increments by exactly 1.
- stall held 3 cycles at pc=7 → pc stays 7 and fetch_valid=0 for 3 cycles; pc=8 on the edge after stall drops.
- Force pc=32'hFFFFFFFF via jump, let the flush expire, run with stall=0 → pc=0 (wrap); separately, assert rst during FLUSH → pc=RESET_PC, flush=0, state BOOT.
- With PC_TRAP_EN: trap at pc=32'h12 → pc=32'h10, epc=32'h12, flush=1; trap together with br_taken → trap wins.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: boot, run, stall and post-redirect flush.
// Optional trap entry (trap input, epc output) is compiled in when PC_TRAP_EN is defined.
module pc_sequencer #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_PC     = '0,
   parameter int unsigned      FLUSH_CYCLES = 1,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0010)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
`ifdef PC_TRAP_EN
   input  logic             trap,
   output logic [WIDTH-1:0] epc,
`endif
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] npc,
   output logic             pc_src,
   output logic             fetch_valid,
   output logic             flush,
   output logic [15:0]      redirect_cnt
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      STALL,
      FLUSH
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t           state;
   state_t           next_state;
   logic [2:0]       flush_cnt;
   logic [2:0]       flush_cnt_next;
   logic             redirect_req;
   logic [WIDTH-1:0] redirect_pc;
   logic [WIDTH-1:0] pc_inc;

   assign pc_inc = pc + WIDTH'(1);

   // Redirect source selection: trap (when built in) > branch > jump; BOOT ignores branch/jump.
   always_comb begin
      redirect_req = 1'b0;
      redirect_pc  = '0;
`ifdef PC_TRAP_EN
      if (trap) begin
         redirect_req = 1'b1;
         redirect_pc  = TRAP_VECTOR;
      end else
`endif
      if ((state != BOOT) && (br_taken || jump)) begin
         redirect_req = 1'b1;
         redirect_pc  = br_taken ? br_target : jump_target;
      end
   end

   always_comb begin
      next_state     = state;
      flush_cnt_next = flush_cnt;
      npc            = pc;
      pc_src         = 1'b0;
      if (redirect_req) begin
         pc_src         = 1'b1;
         npc            = redirect_pc;
         next_state     = FLUSH;
         flush_cnt_next = FLUSH_LOAD;
      end else begin
         case (state)
            BOOT: next_state = RUN;
            RUN, STALL: begin
               if (stall) begin
                  next_state = STALL;
               end else begin
                  npc        = pc_inc;
                  next_state = RUN;
               end
            end
            FLUSH: begin
               // pc stays on the redirect target; leaving FLUSH does not advance it
               if (flush_cnt <= 3'd1) begin
                  next_state = stall ? STALL : RUN;
               end else begin
                  flush_cnt_next = flush_cnt - 3'd1;
               end
            end
            default: next_state = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         fetch_valid  <= 1'b0;
         flush        <= 1'b0;
         redirect_cnt <= '0;
         flush_cnt    <= '0;
`ifdef PC_TRAP_EN
         epc          <= '0;
`endif
      end else begin
         state       <= next_state;
         pc          <= npc;
         fetch_valid <= (next_state == RUN);
         flush       <= (next_state == FLUSH);
         flush_cnt   <= flush_cnt_next;
         if (redirect_req) begin
            redirect_cnt <= redirect_cnt + 16'd1;
         end
`ifdef PC_TRAP_EN
         if (trap) begin
            epc <= pc;
         end
`endif
      end
   end

endmodule
